// File: rtl/array_ctrl_pkg.sv
// Shared types and helpers for the array sequencer slice.
package array_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COMPUTE,
    FLUSH,
    CAPTURE,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int unsigned DEF_ARRAY_SIZE = 4;
  localparam int unsigned DEF_MASK_WIDTH = 4;

  // Ceiling log2 that never returns 0, so single-entry indices keep one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/array_seq_cnt.sv
// Loadable up-counter with terminal-count flag, used for the beat, flush
// and drain counts of the array sequencer.
module array_seq_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Count up on enable; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else if (en)       count <= count + WIDTH'(1);
  end

  assign tc = (count == last);

endmodule

// File: rtl/array_sequencer.sv
// Tile sequencer for the sparse CELL_UNIT array: latch masks, clear,
// stream K beats, flush the result chain, capture, drain rows, done.
// Optional macro ARRAY_SEQ_ZERO_SKIP_EN: zero beats are consumed without
// a MAC enable and counted on skip_cnt.
module array_sequencer
  import array_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int unsigned MASK_WIDTH = DEF_MASK_WIDTH,
  parameter int unsigned K_WIDTH    = 8
) (
  input  logic                                    Clk,
  input  logic                                    Rst,
  input  logic                                    start,
  input  logic [K_WIDTH-1:0]                      k_len,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*MASK_WIDTH-1:0] mask_in,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err_zero_len,
  input  logic                                    feed_valid,
  input  logic                                    feed_zero,
  output logic                                    feed_ready,
  output logic [ARRAY_SIZE*ARRAY_SIZE*MASK_WIDTH-1:0] cell_mask,
  output logic                                    Block_control,
  output logic                                    Control,
  output logic                                    ResultCapture,
  output logic                                    Direction,
  output logic                                    drain_valid,
  input  logic                                    drain_ready,
`ifdef ARRAY_SEQ_ZERO_SKIP_EN
  output logic [K_WIDTH-1:0]                      skip_cnt,
`endif
  output logic [clog2_min1(ARRAY_SIZE)-1:0]       drain_idx
);

  localparam int unsigned IW = clog2_min1(ARRAY_SIZE);

  seq_state_t         state;
  logic [K_WIDTH-1:0] k_len_q;
  logic               zero_len_q;
  logic               beat_fire;
  logic               beat_zero;
  logic               beat_tc;
  logic               flush_tc;
  logic               drain_fire;
  logic               drain_tc;
  logic               cnt_clr;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [IW-1:0]      flush_cnt;
  logic               unused_sigs;

  assign busy       = (state != IDLE);
  assign beat_fire  = feed_ready & feed_valid;
  assign Control    = beat_fire & ~beat_zero;
  assign drain_fire = drain_valid & drain_ready;
  assign cnt_clr    = (state == CLEAR);

`ifdef ARRAY_SEQ_ZERO_SKIP_EN
  assign beat_zero   = feed_zero;
  assign unused_sigs = ^{beat_cnt, flush_cnt};

  // Count zero beats consumed in the current tile; held after done.
  always_ff @(posedge Clk) begin
    if (!Rst || cnt_clr)          skip_cnt <= '0;
    else if (beat_fire && beat_zero) skip_cnt <= skip_cnt + K_WIDTH'(1);
  end
`else
  assign beat_zero   = 1'b0;
  assign unused_sigs = ^{beat_cnt, flush_cnt, feed_zero};
`endif

  array_seq_cnt #(.WIDTH(K_WIDTH)) u_beat_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (cnt_clr),
    .en    (beat_fire),
    .last  (k_len_q - K_WIDTH'(1)),
    .count (beat_cnt),
    .tc    (beat_tc)
  );

  array_seq_cnt #(.WIDTH(IW)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (cnt_clr),
    .en    (state == FLUSH),
    .last  (IW'(ARRAY_SIZE - 2)),
    .count (flush_cnt),
    .tc    (flush_tc)
  );

  array_seq_cnt #(.WIDTH(IW)) u_drain_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (cnt_clr),
    .en    (drain_fire),
    .last  (IW'(ARRAY_SIZE - 1)),
    .count (drain_idx),
    .tc    (drain_tc)
  );

  // Tile control FSM with registered array control outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= IDLE;
      k_len_q       <= '0;
      zero_len_q    <= 1'b0;
      cell_mask     <= '0;
      feed_ready    <= 1'b0;
      Block_control <= 1'b0;
      ResultCapture <= 1'b0;
      Direction     <= 1'b0;
      drain_valid   <= 1'b0;
      done          <= 1'b0;
      err_zero_len  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_len_q       <= k_len;
            zero_len_q    <= (k_len == '0);
            cell_mask     <= mask_in;
            // Zero-length tiles still pass the CLEAR slot (with no clear)
            // so done lands two cycles after start.
            Block_control <= (k_len != '0);
            state         <= CLEAR;
          end
        end
        CLEAR: begin
          Block_control <= 1'b0;
          if (zero_len_q) begin
            done         <= 1'b1;
            err_zero_len <= 1'b1;
            state        <= DONE;
          end else begin
            feed_ready <= 1'b1;
            state      <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (beat_fire && beat_tc) begin
            feed_ready <= 1'b0;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_tc) begin
            ResultCapture <= 1'b1;
            state         <= CAPTURE;
          end
        end
        CAPTURE: begin
          ResultCapture <= 1'b0;
          Direction     <= 1'b1;
          drain_valid   <= 1'b1;
          state         <= DRAIN;
        end
        DRAIN: begin
          if (drain_fire && drain_tc) begin
            Direction   <= 1'b0;
            drain_valid <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done         <= 1'b0;
          err_zero_len <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_sequencer.sv
// Scoreboard bench for array_sequencer: stimulus queues per-tile
// expectations, a negedge monitor pops and checks them on done/abort.
module tb_array_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  k_len = '0;
  logic [63:0] mask_in = '0;
  logic        feed_valid = 1'b1;
  logic        feed_zero = 1'b0;
  logic        drain_ready = 1'b1;
  logic        busy, done, err_zero_len, feed_ready;
  logic [63:0] cell_mask;
  logic        Block_control, Control, ResultCapture, Direction, drain_valid;
  logic [1:0]  drain_idx;
`ifdef ARRAY_SEQ_ZERO_SKIP_EN
  logic [7:0]  skip_cnt;
`endif

  array_sequencer #(.ARRAY_SIZE(4), .MASK_WIDTH(4), .K_WIDTH(8)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .start         (start),
    .k_len         (k_len),
    .mask_in       (mask_in),
    .busy          (busy),
    .done          (done),
    .err_zero_len  (err_zero_len),
    .feed_valid    (feed_valid),
    .feed_zero     (feed_zero),
    .feed_ready    (feed_ready),
    .cell_mask     (cell_mask),
    .Block_control (Block_control),
    .Control       (Control),
    .ResultCapture (ResultCapture),
    .Direction     (Direction),
    .drain_valid   (drain_valid),
    .drain_ready   (drain_ready),
`ifdef ARRAY_SEQ_ZERO_SKIP_EN
    .skip_cnt      (skip_cnt),
`endif
    .drain_idx     (drain_idx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          lat;
    int          ctrl;
    int          err;
    int          blk;
    int          cap;
    int          rows;
    int          skip;
    int          abort;
    logic [63:0] mask;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int tiles_seen = 0;

  // Feeder / writeback pattern configuration
  int gap_after = 0, gap_len = 0, stall_after = 0, stall_len = 0;
  logic [15:0] zmask = '0;
  int beat_n = 0, drn_n = 0, gap_left = 0, stall_left = 0;

  task automatic check(input string nm, input longint got, input longint want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic exp_t mk(input int lat, input int ctrl, input int err, input int blk,
                              input int cap, input int rows, input int skip, input int abort,
                              input logic [63:0] m);
    exp_t e;
    e.lat = lat; e.ctrl = ctrl; e.err = err; e.blk = blk; e.cap = cap;
    e.rows = rows; e.skip = skip; e.abort = abort; e.mask = m;
    return e;
  endfunction

  // Driver: feed gaps, zero beats and drain stalls keyed to handshake counts.
  always @(posedge Clk) begin
    logic ff, df, acc;
    ff  = feed_valid & feed_ready;
    df  = drain_valid & drain_ready;
    acc = Rst & start & ~busy;
    #1;
    if (acc) begin
      beat_n = 0; drn_n = 0; gap_left = 0; stall_left = 0;
    end else begin
      if (ff) beat_n++;
      if (ff && beat_n == gap_after) gap_left = gap_len;
      else if (gap_left > 0) gap_left--;
      if (df) drn_n++;
      if (df && drn_n == stall_after) stall_left = stall_len;
      else if (stall_left > 0) stall_left--;
    end
    feed_valid  = (gap_left == 0);
    feed_zero   = (beat_n + 1 < 16) ? zmask[beat_n + 1] : 1'b0;
    drain_ready = (stall_left == 0);
  end

  // Monitor: per-tile observation, compared against the popped expectation.
  exp_t cur;
  int   active = 0, t = 0, ctrl_n = 0, blk_c = 0, cap_c = 0, bad = 0, drn_exp = 0, rst_chk = 0;
  always @(negedge Clk) begin
    if (active != 0) begin
      t++;
      if (Control) ctrl_n++;
      if (Block_control) blk_c = t;
      if (ResultCapture) cap_c = t;
      if (cell_mask != cur.mask) bad++;
      if (Direction != drain_valid) bad++;
      if (drain_valid && drain_ready) begin
        check("drain_idx", drain_idx, drn_exp);
        drn_exp++;
      end
      if (done) begin
        check("abort_expected", 0, cur.abort);
        check("latency", t, cur.lat);
        check("control_cycles", ctrl_n, cur.ctrl);
        check("err_zero_len", err_zero_len, cur.err);
        check("clear_cycle", blk_c, cur.blk);
        check("capture_cycle", cap_c, cur.cap);
        check("drain_rows", drn_exp, cur.rows);
        check("mask_dir_bad_cycles", bad, 0);
`ifdef ARRAY_SEQ_ZERO_SKIP_EN
        check("skip_cnt", skip_cnt, cur.skip);
`endif
        active = 0;
        tiles_seen++;
      end else if (!Rst) begin
        check("abort_expected", 1, cur.abort);
        active = 0;
        rst_chk = 1;
        tiles_seen++;
      end
    end else begin
      if (rst_chk != 0) begin
        check("post_reset_outputs",
              {busy, done, err_zero_len, feed_ready, Control, Block_control,
               ResultCapture, Direction, drain_valid, |drain_idx, |cell_mask}, 0);
        rst_chk = 0;
      end
      if (done) check("unexpected_done", 1, 0);
    end
    if (Rst && start && !busy && active == 0) begin
      if (q.size() == 0) begin
        check("unexpected_accept", 1, 0);
      end else begin
        cur = q.pop_front();
        active = 1; t = 0; ctrl_n = 0; blk_c = 0; cap_c = 0; bad = 0; drn_exp = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] k, input logic [63:0] m, input exp_t e);
    q.push_back(e);
    @(posedge Clk); #1;
    k_len = k; mask_in = m; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_tile(input int base);
    int n;
    n = 0;
    while (tiles_seen == base && n < 3000) begin
      @(posedge Clk);
      n++;
    end
    if (tiles_seen == base) begin
      check("tile_timeout", 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  endtask

  initial begin
    int base, n;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_state",
          {busy, done, err_zero_len, feed_ready, Control, Block_control,
           ResultCapture, Direction, drain_valid, |drain_idx, |cell_mask}, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // Unstalled k=8 tile; a start during DONE must be ignored.
    base = tiles_seen;
    issue(8'd8, 64'h0123_4567_89AB_CDEF, mk(18, 8, 0, 1, 13, 4, 0, 0, 64'h0123_4567_89AB_CDEF));
    repeat (17) @(posedge Clk);
    #1; k_len = 8'd5; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    wait_tile(base);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("start_in_done_ignored", busy, 0);

    // Feed gap of 3 cycles after the 2nd beat.
    gap_after = 2; gap_len = 3;
    base = tiles_seen;
    issue(8'd4, 64'hFEDC_BA98_7654_3210, mk(17, 4, 0, 1, 12, 4, 0, 0, 64'hFEDC_BA98_7654_3210));
    wait_tile(base);
    gap_after = 0; gap_len = 0;

    // Writeback stalls 5 cycles while row 1 is offered.
    stall_after = 1; stall_len = 5;
    base = tiles_seen;
    issue(8'd8, 64'hA5A5_5A5A_0F0F_F0F0, mk(23, 8, 0, 1, 13, 4, 0, 0, 64'hA5A5_5A5A_0F0F_F0F0));
    wait_tile(base);
    stall_after = 0; stall_len = 0;

    // Zero-length tile.
    base = tiles_seen;
    issue(8'd0, 64'h1111_2222_3333_4444, mk(2, 0, 1, 0, 0, 0, 0, 0, 64'h1111_2222_3333_4444));
    wait_tile(base);

    // Reset mid-COMPUTE after beat 3.
    base = tiles_seen;
    issue(8'd8, 64'hDEAD_BEEF_CAFE_F00D, mk(0, 0, 0, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D));
    n = 0;
    while (beat_n != 3 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("abort_reached_beat3", beat_n, 3);
    @(posedge Clk); #1; Rst = 1'b0;
    @(posedge Clk); #1; Rst = 1'b1;
    wait_tile(base);
    repeat (4) @(posedge Clk);

    // Normal tile after abort.
    base = tiles_seen;
    issue(8'd4, 64'h0000_FFFF_0000_FFFF, mk(14, 4, 0, 1, 9, 4, 0, 0, 64'h0000_FFFF_0000_FFFF));
    wait_tile(base);

    // Maximum beat count must not wrap.
    base = tiles_seen;
    issue(8'd255, 64'hFFFF_FFFF_FFFF_FFFF, mk(265, 255, 0, 1, 260, 4, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF));
    wait_tile(base);

    // Zero beats 2 and 5 of 6.
    zmask = 16'h0024;
    base = tiles_seen;
`ifdef ARRAY_SEQ_ZERO_SKIP_EN
    issue(8'd6, 64'h1357_9BDF_2468_ACE0, mk(16, 4, 0, 1, 11, 4, 2, 0, 64'h1357_9BDF_2468_ACE0));
`else
    issue(8'd6, 64'h1357_9BDF_2468_ACE0, mk(16, 6, 0, 1, 11, 4, 0, 0, 64'h1357_9BDF_2468_ACE0));
`endif
    wait_tile(base);
    zmask = '0;

    repeat (4) @(posedge Clk);
    check("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
